// File: rtl/rocketcpu_param_smoother_pkg.sv
// Shared types and default build parameters for the audio parameter smoother.
// Optional overrun counter is enabled with RKT_SMOOTHER_OVERRUN_EN.
package rocketcpu_param_smoother_pkg;

    localparam int DEF_NCH   = 4;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHIFT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Index width that stays legal when only one channel is configured.
    function automatic int idx_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/rocketcpu_param_smoother_if.sv
// Register-bank side bundle of the parameter smoother: targets and strobes in, smoothed values out.
// o_overrun exists only when RKT_SMOOTHER_OVERRUN_EN is defined.
interface rocketcpu_param_smoother_if
    import rocketcpu_param_smoother_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [NCH*WIDTH-1:0] i_target;
    logic                 i_sample_strobe;
    logic                 i_snap;
    logic [NCH*WIDTH-1:0] o_params;
    logic [NCH-1:0]       o_settled;
    logic                 o_busy;
    logic                 o_frame_done;
`ifdef RKT_SMOOTHER_OVERRUN_EN
    logic [7:0]           o_overrun;

    modport master (
        output i_target, i_sample_strobe, i_snap,
        input  o_params, o_settled, o_busy, o_frame_done, o_overrun
    );

    modport slave (
        input  i_target, i_sample_strobe, i_snap,
        output o_params, o_settled, o_busy, o_frame_done, o_overrun
    );
`else
    modport master (
        output i_target, i_sample_strobe, i_snap,
        input  o_params, o_settled, o_busy, o_frame_done
    );

    modport slave (
        input  i_target, i_sample_strobe, i_snap,
        output o_params, o_settled, o_busy, o_frame_done
    );
`endif

endinterface

// File: rtl/rocketcpu_param_smoother_step.sv
// One exponential smoothing step: moves cur toward target by diff >>> SHIFT, at least one LSB.
// Purely combinational; shared across channels by the sweeping top level.
module rocketcpu_param_step
    import rocketcpu_param_smoother_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] next_val,
    output logic             settled
);

    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] step;

    // NOTE: every variable gets a value before any conditional so no latch is inferred.
    always_comb begin
        diff = $signed({1'b0, target}) - $signed({1'b0, cur});
        step = diff >>> SHIFT;
        // Small positive gaps would otherwise stall; negative ones already floor to -1.
        if (step == '0 && diff > 0) begin
            step = {{WIDTH{1'b0}}, 1'b1};
        end
        next_val = cur + step[WIDTH-1:0];
        settled  = (next_val == target);
    end

endmodule

// File: rtl/rocketcpu_param_smoother.sv
// Sweeps NCH parameter channels one per clock after each sample strobe, smoothing toward targets.
// Define RKT_SMOOTHER_OVERRUN_EN to count strobes that arrive while a sweep is still running.
module rocketcpu_param_smoother
    import rocketcpu_param_smoother_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHIFT = DEF_SHIFT
) (
    input logic                       i_wb_clk,
    input logic                       i_wb_rst,
    rocketcpu_param_smoother_if.slave bus
);

    localparam int IDX_W = idx_width(NCH);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               busy;
    logic               frame_done;
    logic [NCH-1:0]     settled;
    logic [WIDTH-1:0]   cur [NCH];
    logic [WIDTH-1:0]   tgt [NCH];
    logic [WIDTH-1:0]   step_next;
    logic               step_settled;
`ifdef RKT_SMOOTHER_OVERRUN_EN
    logic [7:0]         overrun;
`endif

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            tgt[k] = bus.i_target[k*WIDTH +: WIDTH];
        end
    end

    rocketcpu_param_step #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_step (
        .cur      (cur[idx]),
        .target   (tgt[idx]),
        .next_val (step_next),
        .settled  (step_settled)
    );

    // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            settled    <= '0;
            // NOTE: the channel array is small and its outputs must read 0 out of reset, so it is reset.
            for (int k = 0; k < NCH; k++) begin
                cur[k] <= '0;
            end
`ifdef RKT_SMOOTHER_OVERRUN_EN
            overrun    <= '0;
`endif
        end else if (bus.i_snap) begin
            state      <= ST_IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            settled    <= '1;
            for (int k = 0; k < NCH; k++) begin
                cur[k] <= tgt[k];
            end
`ifdef RKT_SMOOTHER_OVERRUN_EN
            overrun    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
`ifdef RKT_SMOOTHER_OVERRUN_EN
            if (bus.i_sample_strobe && busy && overrun != 8'hFF) begin
                overrun <= overrun + 8'd1;
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (bus.i_sample_strobe) begin
                        state <= ST_SWEEP;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    cur[idx]     <= step_next;
                    settled[idx] <= step_settled;
                    if (idx == IDX_W'(NCH - 1)) begin
                        state      <= ST_DONE;
                        idx        <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.o_params = '0;
        for (int k = 0; k < NCH; k++) begin
            bus.o_params[k*WIDTH +: WIDTH] = cur[k];
        end
    end

    assign bus.o_settled    = settled;
    assign bus.o_busy       = busy;
    assign bus.o_frame_done = frame_done;
`ifdef RKT_SMOOTHER_OVERRUN_EN
    assign bus.o_overrun    = overrun;
`endif

endmodule

// File: tb/tb_rocketcpu_param_smoother.sv
// Directed bench for rocketcpu_param_smoother with NCH=4, WIDTH=32, SHIFT=4.
// Overrun checks are compiled in only when RKT_SMOOTHER_OVERRUN_EN is defined.
module tb_rocketcpu_param_smoother;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    rocketcpu_param_smoother_if #(.NCH(4), .WIDTH(32)) bus ();

    rocketcpu_param_smoother #(
        .NCH   (4),
        .WIDTH (32),
        .SHIFT (4)
    ) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ch(input int k);
        return bus.o_params[k*32 +: 32];
    endfunction

    task automatic set_tgt(input int k, input logic [31:0] v);
        bus.i_target[k*32 +: 32] = v;
    endtask

    // Strobe once from IDLE, expect frame_done on the 5th edge counting the strobe edge.
    task automatic run_frame(input string tag);
        int n;
        bus.i_sample_strobe = 1'b1;
        tick();
        bus.i_sample_strobe = 1'b0;
        n = 1;
        while (bus.o_frame_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'd5);
        tick();
        check({tag, "_idle"}, 128'(bus.o_busy), 128'd0);
    endtask

    initial begin
        int n_fd;
        int n_busy;
        vectors             = 0;
        miscompares         = 0;
        rst                 = 1'b1;
        bus.i_sample_strobe = 1'b0;
        bus.i_snap          = 1'b0;
        bus.i_target        = '0;

        tick();
        tick();
        check("rst_params", bus.o_params, 128'd0);
        check("rst_settled", 128'(bus.o_settled), 128'd0);
        check("rst_busy", 128'(bus.o_busy), 128'd0);
        check("rst_fd", 128'(bus.o_frame_done), 128'd0);
        rst = 1'b0;

        set_tgt(0, 32'h100);
        set_tgt(1, 32'd5);
        set_tgt(2, 32'h10);
        set_tgt(3, 32'd0);

        // Frame 1 step by step, with a second strobe two cycles in that must be ignored.
        bus.i_sample_strobe = 1'b1;
        tick();
        bus.i_sample_strobe = 1'b0;
        check("f1_busy_start", 128'(bus.o_busy), 128'd1);
        check("f1_fd_early", 128'(bus.o_frame_done), 128'd0);
        tick();
        check("f1_ch0", 128'(ch(0)), 128'h10);
        bus.i_sample_strobe = 1'b1;
        tick();
        bus.i_sample_strobe = 1'b0;
        check("f1_ch1", 128'(ch(1)), 128'd1);
        tick();
        check("f1_ch2", 128'(ch(2)), 128'd1);
        check("f1_fd_mid", 128'(bus.o_frame_done), 128'd0);
        tick();
        check("f1_fd_pulse", 128'(bus.o_frame_done), 128'd1);
        check("f1_busy_done", 128'(bus.o_busy), 128'd1);
        check("f1_ch3", 128'(ch(3)), 128'd0);
        tick();
        check("f1_fd_clear", 128'(bus.o_frame_done), 128'd0);
        check("f1_busy_clear", 128'(bus.o_busy), 128'd0);
        n_fd   = 0;
        n_busy = 0;
        repeat (8) begin
            tick();
            if (bus.o_frame_done === 1'b1) n_fd++;
            if (bus.o_busy === 1'b1) n_busy++;
        end
        check("f1_no_resweep_busy", 128'(n_busy), 128'd0);
        check("f1_no_resweep_fd", 128'(n_fd), 128'd0);
        check("f1_settled", 128'(bus.o_settled), 128'b1000);
`ifdef RKT_SMOOTHER_OVERRUN_EN
        check("f1_overrun", 128'(bus.o_overrun), 128'd1);
`endif

        run_frame("f2");
        check("f2_ch0", 128'(ch(0)), 128'h1F);
        check("f2_ch1", 128'(ch(1)), 128'd2);
        check("f2_ch2", 128'(ch(2)), 128'd2);
        run_frame("f3");
        run_frame("f4");
        check("f4_ch1", 128'(ch(1)), 128'd4);
        check("f4_settled1", 128'(bus.o_settled[1]), 128'd0);
        run_frame("f5");
        check("f5_ch1", 128'(ch(1)), 128'd5);
        check("f5_ch0", 128'(ch(0)), 128'h46);
        check("f5_settled", 128'(bus.o_settled), 128'b1010);

        // Snap puts ch2 at 0x10, then walk it down to 0 with target 0.
        bus.i_snap = 1'b1;
        tick();
        bus.i_snap = 1'b0;
        check("snap1_ch2", 128'(ch(2)), 128'h10);
        check("snap1_settled", 128'(bus.o_settled), 128'hF);
`ifdef RKT_SMOOTHER_OVERRUN_EN
        check("snap1_overrun", 128'(bus.o_overrun), 128'd0);
`endif
        set_tgt(2, 32'd0);
        run_frame("dn1");
        check("dn1_ch2", 128'(ch(2)), 128'hF);
        check("dn1_settled", 128'(bus.o_settled), 128'b1011);
        for (int i = 0; i < 15; i++) begin
            run_frame("dn");
        end
        check("dn_ch2_zero", 128'(ch(2)), 128'd0);
        check("dn_settled", 128'(bus.o_settled), 128'hF);
        run_frame("dn_extra");
        check("dn_no_underflow", 128'(ch(2)), 128'd0);

        // Snap in the middle of a sweep.
        bus.i_sample_strobe = 1'b1;
        tick();
        bus.i_sample_strobe = 1'b0;
        tick();
        set_tgt(0, 32'hAAAA);
        set_tgt(1, 32'd1);
        set_tgt(2, 32'd2);
        set_tgt(3, 32'd3);
        bus.i_snap = 1'b1;
        tick();
        bus.i_snap = 1'b0;
        check("snap2_params", bus.o_params, {32'd3, 32'd2, 32'd1, 32'hAAAA});
        check("snap2_settled", 128'(bus.o_settled), 128'hF);
        check("snap2_busy", 128'(bus.o_busy), 128'd0);
        check("snap2_fd", 128'(bus.o_frame_done), 128'd0);
        n_fd = 0;
        repeat (6) begin
            tick();
            if (bus.o_frame_done === 1'b1) n_fd++;
        end
        check("snap2_no_fd", 128'(n_fd), 128'd0);

        // A strobe coinciding with snap is dropped.
        bus.i_snap          = 1'b1;
        bus.i_sample_strobe = 1'b1;
        tick();
        bus.i_snap          = 1'b0;
        bus.i_sample_strobe = 1'b0;
        check("snap_strobe_dropped", 128'(bus.o_busy), 128'd0);

        // Reset in the middle of a sweep, then a clean sweep.
        bus.i_sample_strobe = 1'b1;
        tick();
        bus.i_sample_strobe = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_params", bus.o_params, 128'd0);
        check("mrst_settled", 128'(bus.o_settled), 128'd0);
        check("mrst_busy", 128'(bus.o_busy), 128'd0);
        check("mrst_fd", 128'(bus.o_frame_done), 128'd0);
        n_fd = 0;
        repeat (6) begin
            tick();
            if (bus.o_frame_done === 1'b1) n_fd++;
        end
        check("mrst_no_fd", 128'(n_fd), 128'd0);
        run_frame("post_rst");
        check("post_rst_params", bus.o_params, {32'd1, 32'd1, 32'd1, 32'hAAA});
        check("post_rst_settled", 128'(bus.o_settled), 128'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
